conv_seq_ctrl: RTL and testbench

Sequencing controller for the 1-D convolution datapath: x-sample memory, f coefficient ROM, saturating MAC with ReLU output register. It owns the x input handshake, generates all memory and ROM addresses, drives accumulator enables, and owns the y output handshake. It replaces per-block ad hoc control with a single explicit FSM, and sits between the stream ports and the datapath inside each `conv_<LENX>_<LENF>_<WIDTH>_*` top.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_addr_gen.sv | 79 +++++++
 rtl/conv_seq_ctrl.sv | 111 +++++++++++
 tb/tb_conv_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution sequencing controller.
package conv_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } conv_state_t;

    // Number of valid (full-overlap) outputs per frame.
    function automatic int unsigned conv_nout(input int unsigned lenx, input int unsigned lenf);
        return lenx - lenf + 32'd1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Frame counters, memory/ROM address mux and the one-deep issue pipe that
// lines the accumulator strobes up with the 1-cycle read latency.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned LENX  = 30,
    parameter int unsigned LENF  = 9,
    parameter int unsigned ADDRX = 5,
    parameter int unsigned ADDRF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  conv_state_t       state,
    input  logic              wr_acc,
    input  logic              y_xfer,
    output logic [ADDRX-1:0]  addr_x,
    output logic [ADDRF-1:0]  addr_f,
    output logic              en_acc,
    output logic              clr_acc,
    output logic              last_w,
    output logic              last_k,
    output logic              last_n
);

    localparam int unsigned       NOUT   = conv_nout(LENX, LENF);
    localparam logic [ADDRX-1:0]  W_LAST = ADDRX'(LENX - 1);
    localparam logic [ADDRF-1:0]  K_LAST = ADDRF'(LENF - 1);
    localparam logic [ADDRX-1:0]  N_LAST = ADDRX'(NOUT - 1);

    logic [ADDRX-1:0] wcnt;
    logic [ADDRX-1:0] n;
    logic [ADDRF-1:0] k;

    assign last_w = (wcnt == W_LAST);
    assign last_k = (k == K_LAST);
    assign last_n = (n == N_LAST);

    // k wraps to 0 on the last tap and n on the last output, so both are
    // already zero whenever a new output or a new frame begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt    <= '0;
            n       <= '0;
            k       <= '0;
            en_acc  <= 1'b0;
            clr_acc <= 1'b0;
        end else begin
            en_acc  <= (state == S_ISSUE);
            clr_acc <= (state == S_ISSUE) && (k == '0);
            if (wr_acc) begin
                wcnt <= last_w ? '0 : wcnt + ADDRX'(1);
            end
            if (state == S_ISSUE) begin
                k <= last_k ? '0 : k + ADDRF'(1);
            end
            if (y_xfer) begin
                n <= last_n ? '0 : n + ADDRX'(1);
            end
        end
    end

    // n + k never exceeds LENX-1, so the sum fits ADDRX bits without wrap.
    always_comb begin
        addr_x = '0;
        addr_f = '0;
        case (state)
            S_LOAD: begin
                addr_x = wcnt;
            end
            S_ISSUE: begin
                addr_x = n + ADDRX'(k);
                addr_f = k;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for the 1-D convolution datapath: loads a frame of x,
// issues LENF taps per output, then holds each y until the sink accepts it.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned LENX  = 30,
    parameter int unsigned LENF  = 9,
    parameter int unsigned ADDRX = 5,
    parameter int unsigned ADDRF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_x,
    output logic              s_ready_x,
    output logic              m_valid_y,
    input  logic              m_ready_y,
    output logic              wr_en_x,
    output logic [ADDRX-1:0]  addr_x,
    output logic [ADDRF-1:0]  addr_f,
    output logic              en_acc,
    output logic              clr_acc,
    output logic              frame_done
);

    conv_state_t      state;
    conv_state_t      state_nxt;
    logic             wr_acc;
    logic             y_xfer;
    logic             last_w;
    logic             last_k;
    logic             last_n;
    logic [ADDRX-1:0] gen_addr_x;
    logic [ADDRF-1:0] gen_addr_f;

    conv_addr_gen #(
        .LENX  (LENX),
        .LENF  (LENF),
        .ADDRX (ADDRX),
        .ADDRF (ADDRF)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .wr_acc  (wr_acc),
        .y_xfer  (y_xfer),
        .addr_x  (gen_addr_x),
        .addr_f  (gen_addr_f),
        .en_acc  (en_acc),
        .clr_acc (clr_acc),
        .last_w  (last_w),
        .last_k  (last_k),
        .last_n  (last_n)
    );

    // frame_done is registered so no output depends on m_ready_y; it pulses
    // in the cycle after the final transfer, together with s_ready_x rising.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= y_xfer && last_n;
        end
    end

    // Handshake and address outputs are held at their idle values while reset is high.
    always_comb begin
        state_nxt = state;
        s_ready_x = 1'b0;
        wr_en_x   = 1'b0;
        m_valid_y = 1'b0;
        wr_acc    = 1'b0;
        y_xfer    = 1'b0;
        addr_x    = '0;
        addr_f    = '0;
        if (!reset) begin
            addr_x = gen_addr_x;
            addr_f = gen_addr_f;
            case (state)
                S_LOAD: begin
                    s_ready_x = 1'b1;
                    wr_en_x   = s_valid_x;
                    wr_acc    = s_valid_x;
                    if (s_valid_x && last_w) begin
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (last_k) begin
                        state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state_nxt = S_OUT;
                end
                S_OUT: begin
                    m_valid_y = 1'b1;
                    y_xfer    = m_ready_y;
                    if (m_ready_y) begin
                        state_nxt = last_n ? S_LOAD : S_ISSUE;
                    end
                end
                default: begin
                    state_nxt = S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: 8/4 timing and back-pressure, 30/9 random
// handshakes over three frames, and the LENF == LENX single-output corner.
module tb_conv_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instance A: LENX=8, LENF=4
    logic       rst_a, sv_a, sr_a, mv_a, mr_a, we_a, ea_a, ca_a, fd_a;
    logic [2:0] ax_a;
    logic [1:0] af_a;
    conv_seq_ctrl #(.LENX(8), .LENF(4), .ADDRX(3), .ADDRF(2)) dut_a (
        .clk(clk), .reset(rst_a), .s_valid_x(sv_a), .s_ready_x(sr_a),
        .m_valid_y(mv_a), .m_ready_y(mr_a), .wr_en_x(we_a), .addr_x(ax_a),
        .addr_f(af_a), .en_acc(ea_a), .clr_acc(ca_a), .frame_done(fd_a));

    // Instance B: LENX=30, LENF=9
    logic       rst_b, sv_b, sr_b, mv_b, mr_b, we_b, ea_b, ca_b, fd_b;
    logic [4:0] ax_b;
    logic [3:0] af_b;
    conv_seq_ctrl #(.LENX(30), .LENF(9), .ADDRX(5), .ADDRF(4)) dut_b (
        .clk(clk), .reset(rst_b), .s_valid_x(sv_b), .s_ready_x(sr_b),
        .m_valid_y(mv_b), .m_ready_y(mr_b), .wr_en_x(we_b), .addr_x(ax_b),
        .addr_f(af_b), .en_acc(ea_b), .clr_acc(ca_b), .frame_done(fd_b));

    // Instance C: LENX=LENF=4
    logic       rst_c, sv_c, sr_c, mv_c, mr_c, we_c, ea_c, ca_c, fd_c;
    logic [1:0] ax_c;
    logic [1:0] af_c;
    conv_seq_ctrl #(.LENX(4), .LENF(4), .ADDRX(2), .ADDRF(2)) dut_c (
        .clk(clk), .reset(rst_c), .s_valid_x(sv_c), .s_ready_x(sr_c),
        .m_valid_y(mv_c), .m_ready_y(mr_c), .wr_en_x(we_c), .addr_x(ax_c),
        .addr_f(af_c), .en_acc(ea_c), .clr_acc(ca_c), .frame_done(fd_c));

    int xa[$];
    int fa[$];
    int en_a[5];
    int clr_a[5];
    int exp_xa[5] = '{13, 19, 25, 31, 37};

    initial begin
        int t;
        int bad;
        int xc, fdc, enc_c, clc_c;
        int frames, wcount, xf, enc, clc, bad_rdy, bad_out, bad_waddr, bad_we;
        bit computing;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        sv_a = 1'b1; sv_b = 1'b0; sv_c = 1'b0;
        mr_a = 1'b1; mr_b = 1'b0; mr_c = 1'b0;
        foreach (en_a[i]) begin en_a[i] = 0; clr_a[i] = 0; end

        // ---- reset values (s_valid_x high must not leak through)
        cyc(); #1;
        check("rst_s_ready",    32'(sr_a), 0);
        check("rst_wr_en",      32'(we_a), 0);
        check("rst_m_valid",    32'(mv_a), 0);
        check("rst_en_acc",     32'(ea_a), 0);
        check("rst_clr_acc",    32'(ca_a), 0);
        check("rst_frame_done", 32'(fd_a), 0);
        check("rst_addr_x",     32'(ax_a), 0);
        check("rst_addr_f",     32'(af_a), 0);

        // ---- A: full frame with s_valid_x/m_ready_y tied high
        cyc();
        rst_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c < 8) begin
                check("a_wr_en", 32'(we_a), 1);
                check("a_wr_addr", 32'(ax_a), 32'(c));
            end
            if (c == 0) check("a_ready_first", 32'(sr_a), 1);
            if (c == 8) check("a_ready_compute", 32'(sr_a), 0);
            if (c >= 14 && c <= 17) begin
                check("a_n1_addr_x", 32'(ax_a), 32'(c - 13));
                check("a_n1_addr_f", 32'(af_a), 32'(c - 14));
            end
            if (c == 12) begin
                check("a_drain_m_valid", 32'(mv_a), 0);
                check("a_drain_addr_x", 32'(ax_a), 0);
                check("a_drain_en_acc", 32'(ea_a), 1);
            end
            if (c == 13) check("a_out_m_valid", 32'(mv_a), 1);
            if (c == 38) check("a_ready_next_frame", 32'(sr_a), 1);
            if (ea_a && xa.size() < 5) begin
                if (ca_a && en_a[xa.size()] != 0) clr_a[xa.size()] += 10;
                en_a[xa.size()]++;
                if (ca_a) clr_a[xa.size()]++;
            end
            if (mv_a && mr_a) xa.push_back(c);
            if (fd_a) fa.push_back(c);
            cyc();
        end
        check("a_xfer_count", 32'(xa.size()), 5);
        for (int i = 0; i < 5; i++) begin
            check("a_xfer_cycle", (i < xa.size()) ? 32'(xa[i]) : 32'hFFFF_FFFF, 32'(exp_xa[i]));
            check("a_en_per_out", 32'(en_a[i]), 4);
            check("a_clr_first_only", 32'(clr_a[i]), 1);
        end
        check("a_fd_count", 32'(fa.size()), 1);
        check("a_fd_cycle", (fa.size() > 0) ? 32'(fa[0]) : 32'hFFFF_FFFF, 38);

        // ---- A: back-pressure in S_OUT
        rst_a = 1'b1; sv_a = 1'b0; mr_a = 1'b0;
        cyc();
        rst_a = 1'b0; sv_a = 1'b1;
        t = 0;
        #1;
        while (!mv_a && t < 40) begin cyc(); #1; t++; end
        check("a_bp_reach_out", 32'(mv_a), 1);
        check("a_bp_latency", 32'(t), 13);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            if (mv_a !== 1'b1 || ea_a !== 1'b0 || ax_a !== 3'd0 || af_a !== 2'd0) bad++;
        end
        check("a_bp_hold", 32'(bad), 0);
        cyc(); mr_a = 1'b1; #1;
        check("a_bp_release_valid", 32'(mv_a), 1);
        cyc(); #1;
        check("a_bp_one_xfer", 32'(mv_a), 0);
        check("a_bp_next_addr_x", 32'(ax_a), 1);
        check("a_bp_next_en", 32'(ea_a), 0);

        // ---- A: reset while issuing n=2
        t = 0;
        while (!mv_a && t < 20) begin cyc(); #1; t++; end
        check("a_n1_reach_out", 32'(mv_a), 1);
        cyc(); #1;
        check("a_n2_issue_addr_x", 32'(ax_a), 2);
        check("a_n2_issue_ready", 32'(sr_a), 0);
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0; sv_a = 1'b0;
        #1;
        check("a_mid_rst_ready", 32'(sr_a), 1);
        check("a_mid_rst_m_valid", 32'(mv_a), 0);
        check("a_mid_rst_en_acc", 32'(ea_a), 0);
        check("a_mid_rst_clr_acc", 32'(ca_a), 0);
        cyc(); sv_a = 1'b1; #1;
        check("a_mid_rst_wr_en", 32'(we_a), 1);
        check("a_mid_rst_wr_addr", 32'(ax_a), 0);
        cyc(); #1;
        check("a_mid_rst_wr_addr2", 32'(ax_a), 1);
        check("a_mid_rst_en_later", 32'(ea_a), 0);
        sv_a = 1'b0;

        // ---- C: LENF == LENX, one output per frame
        cyc();
        rst_c = 1'b0; sv_c = 1'b1; mr_c = 1'b1;
        xc = 0; fdc = 0; enc_c = 0; clc_c = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c == 6) begin
                check("c_issue_addr_x", 32'(ax_c), 2);
                check("c_issue_addr_f", 32'(af_c), 2);
            end
            if (c == 3) check("c_last_wr", 32'({we_c, ax_c}), 32'({1'b1, 2'd3}));
            if (c == 8) check("c_drain_m_valid", 32'(mv_c), 0);
            if (c == 9) check("c_out_xfer", 32'(mv_c & mr_c), 1);
            if (c == 10) begin
                check("c_fd_pulse", 32'(fd_c), 1);
                check("c_ready_after", 32'(sr_c), 1);
                check("c_new_frame_addr", 32'(ax_c), 0);
            end
            if (c < 10) begin
                if (mv_c && mr_c) xc++;
                if (fd_c) fdc++;
                if (ea_c) enc_c++;
                if (ca_c) clc_c++;
            end
            cyc();
        end
        check("c_xfer_count", 32'(xc), 1);
        check("c_fd_early", 32'(fdc), 0);
        check("c_en_count", 32'(enc_c), 4);
        check("c_clr_count", 32'(clc_c), 1);
        sv_c = 1'b0;

        // ---- B: random handshakes, three frames of LENX=30, LENF=9
        cyc();
        rst_b = 1'b0;
        sv_b = 1'($urandom_range(0, 1));
        mr_b = 1'($urandom_range(0, 1));
        frames = 0; wcount = 0; xf = 0; enc = 0; clc = 0;
        bad_rdy = 0; bad_out = 0; bad_waddr = 0; bad_we = 0;
        computing = 1'b0;
        #1;
        for (int c = 0; c < 6000 && frames < 3; c++) begin
            if (we_b !== (sv_b & sr_b)) bad_we++;
            if (computing && sr_b && !fd_b) bad_rdy++;
            if (mv_b && (ax_b != 5'd0 || af_b != 4'd0 || ea_b)) bad_out++;
            if (ea_b) enc++;
            if (ca_b) clc++;
            if (mv_b && mr_b) xf++;
            if (fd_b) begin
                check("b_frame_xfers", 32'(xf), 22);
                check("b_frame_en", 32'(enc), 198);
                check("b_frame_clr", 32'(clc), 22);
                check("b_ready_at_fd", 32'(sr_b), 1);
                check("b_fd_after_load", 32'(computing), 1);
                xf = 0; enc = 0; clc = 0;
                computing = 1'b0;
                frames++;
            end
            if (we_b) begin
                if (ax_b != 5'(wcount)) bad_waddr++;
                wcount++;
                if (wcount == 30) begin
                    wcount = 0;
                    computing = 1'b1;
                end
            end
            cyc();
            sv_b = 1'($urandom_range(0, 1));
            mr_b = 1'($urandom_range(0, 1));
            #1;
        end
        check("b_frames_done", 32'(frames), 3);
        check("b_ready_in_compute", 32'(bad_rdy), 0);
        check("b_out_quiet", 32'(bad_out), 0);
        check("b_wr_addr", 32'(bad_waddr), 0);
        check("b_wr_en", 32'(bad_we), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
